// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO holding {pc, instr} words between ROM and decode.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned W = $bits(fetch_entry_t)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;

  // Flush drops all entries; a concurrent pop has already been taken by the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses the ROM and feeds decode
// through a two-entry buffer with valid/ready handshake.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned          ADDR_W    = DEF_ADDR_W,
  parameter int unsigned          DATA_W    = DEF_DATA_W,
  parameter logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(14)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_instr,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

  state_e              state, state_nx;
  logic [ADDR_W-1:0]   pc, pc_nx;
  logic                fifo_push, fifo_flush, fifo_full, fifo_empty, pop;
  logic [ENTRY_W-1:0]  fifo_din, fifo_dout;

  assign pop       = out_valid && out_ready;
  assign fifo_din  = {pc, rom_instr};
  assign out_valid = !fifo_empty;
  assign {out_pc, out_instr} = fifo_dout;
  assign rom_addr  = pc;

  // Next-state, PC and buffer control; a redirect overrides any push that cycle.
  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx   = FETCH;
          pc_nx      = '0;
          fifo_flush = 1'b1;
        end
      end
      FETCH: begin
        if (redirect_valid) begin
          fifo_flush = 1'b1;
          pc_nx      = redirect_addr;
          state_nx   = (redirect_addr <= LAST_ADDR) ? FETCH : DRAIN;
        end else if (!fifo_full || pop) begin
          fifo_push = 1'b1;
          if (pc == LAST_ADDR) begin
            state_nx = DRAIN;
          end else begin
            pc_nx = pc + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          fifo_flush = 1'b1;
          pc_nx      = redirect_addr;
          state_nx   = (redirect_addr <= LAST_ADDR) ? FETCH : DRAIN;
        end else if (fifo_empty || (pop && !fifo_full)) begin
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      busy  <= (state_nx == FETCH) || (state_nx == DRAIN);
      done  <= (state_nx == DONE);
    end
  end

  fetch_fifo #(.W(ENTRY_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (fifo_flush),
    .push  (fifo_push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, hand sequences and
// a random stream-level scoreboard against the ROM pattern A000_0000 | addr.
module tb_fetch_ctrl;

  localparam int LAST = 14;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        redirect_valid;
  logic [4:0]  redirect_addr;
  logic [4:0]  rom_addr;
  logic [31:0] rom_instr;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [4:0]  out_pc;
  logic        out_ready;
  logic        busy;
  logic        done;

  int n_cmp;
  int n_bad;

  fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .rom_addr       (rom_addr),
    .rom_instr      (rom_instr),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .busy           (busy),
    .done           (done)
  );

  assign rom_instr = 32'hA000_0000 | 32'(rom_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       start;
    logic       rv;
    logic [4:0] ra;
    logic       rdy;
    logic       e_valid;
    logic [4:0] e_pc;
    logic       chk_pc;
    logic [4:0] e_rom;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t tbl [14];

  function automatic logic [31:0] rom_word(input int a);
    return 32'hA000_0000 | 32'(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_rom_addr"},  64'(rom_addr),  64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_done"},      64'(done),      64'd0);
  endtask

  task automatic do_reset();
    start = 1'b0; redirect_valid = 1'b0; redirect_addr = 5'd0; out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_next, target, redirects, cycles, prev_pc;
    bit over, prev_hold, redir, rdy;
    logic [4:0] raddr;

    n_cmp = 0;
    n_bad = 0;

    tbl[0]  = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 5'd0, 1'b1, 5'd1,  1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 5'd0, 1'b1, 5'd2,  1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 5'd0, 1'b1, 5'd2,  1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 5'd0, 1'b1, 5'd2,  1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 5'd1, 1'b1, 5'd3,  1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 5'd2, 1'b1, 5'd4,  1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 5'd3, 1'b1, 5'd5,  1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 5'd9,  1'b1, 1'b0, 5'd0, 1'b0, 5'd9,  1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 5'd20, 1'b1, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 5'd0, 1'b0, 5'd20, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 5'd3,  1'b1, 1'b0, 5'd0, 1'b0, 5'd20, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 1'b0};

    // Reset values, then a redirect while IDLE must be ignored.
    do_reset();
    check_idle_outs("reset");
    check("reset_out_pc",    64'(out_pc),    64'd0);
    check("reset_out_instr", 64'(out_instr), 64'd0);
    redirect_valid = 1'b1; redirect_addr = 5'd7; out_ready = 1'b1;
    @(posedge clk); #1;
    check_idle_outs("idle_redirect");
    @(negedge clk);
    redirect_valid = 1'b0;

    // Directed vector table: backpressure, redirect-to-9, redirect past end, DONE.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      start = tbl[i].start; redirect_valid = tbl[i].rv;
      redirect_addr = tbl[i].ra; out_ready = tbl[i].rdy;
      @(posedge clk); #1;
      check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_valid));
      check($sformatf("vec%0d_rom_addr", i),  64'(rom_addr),  64'(tbl[i].e_rom));
      check($sformatf("vec%0d_busy", i),      64'(busy),      64'(tbl[i].e_busy));
      check($sformatf("vec%0d_done", i),      64'(done),      64'(tbl[i].e_done));
      if (tbl[i].chk_pc) begin
        check($sformatf("vec%0d_out_pc", i),    64'(out_pc),    64'(tbl[i].e_pc));
        check($sformatf("vec%0d_out_instr", i), 64'(out_instr), 64'(rom_word(int'(tbl[i].e_pc))));
      end
    end

    // Full-rate run: 15 words on consecutive cycles, then done right after.
    do_reset();
    @(negedge clk);
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int i = 0; i <= LAST; i++) begin
      check($sformatf("burst%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("burst%0d_pc", i),    64'(out_pc),    64'(i));
      check($sformatf("burst%0d_instr", i), 64'(out_instr), 64'(rom_word(i)));
      check($sformatf("burst%0d_rom_range", i), 64'(rom_addr > 5'd14), 64'd0);
      @(negedge clk);
    end
    check("burst_done",  64'(done),      64'd1);
    check("burst_busy",  64'(busy),      64'd0);
    check("burst_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset between edges during FETCH.
    @(negedge clk);
    start = 1'b1; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outs("async_rst");
    check("async_rst_out_pc",    64'(out_pc),    64'd0);
    check("async_rst_out_instr", 64'(out_instr), 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_idle_outs("post_rst_idle");

    // Random backpressure and redirects against a stream-level scoreboard.
    for (int run = 0; run < 20; run++) begin
      @(negedge clk);
      start = 1'b1; redirect_valid = 1'b0; out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      start = 1'b0;
      exp_next = 0; over = 1'b0; redirects = 0; cycles = 0; prev_hold = 1'b0; prev_pc = 0;
      while (!done && cycles < 400) begin
        if (prev_hold) begin
          check("rnd_hold_valid", 64'(out_valid), 64'd1);
          check("rnd_hold_pc",    64'(out_pc),    64'(prev_pc));
        end
        if (!over) check("rnd_rom_range", 64'(rom_addr > 5'd14), 64'd0);
        rdy   = ($urandom_range(0, 9) < 7);
        redir = (redirects < 3) && ($urandom_range(0, 15) == 0);
        raddr = 5'($urandom_range(0, 31));
        out_ready = rdy; redirect_valid = redir; redirect_addr = raddr;
        if (out_valid && rdy) begin
          check("rnd_pop_pc",    64'(out_pc),    64'(exp_next));
          check("rnd_pop_instr", 64'(out_instr), 64'(rom_word(exp_next)));
          exp_next++;
        end
        if (redir) begin
          target = int'(raddr);
          exp_next = target;
          over = (target > LAST);
          redirects++;
        end
        prev_hold = out_valid && !rdy && !redir;
        prev_pc   = int'(out_pc);
        @(negedge clk);
        redirect_valid = 1'b0;
        cycles++;
      end
      check($sformatf("rnd%0d_done", run), 64'(done), 64'd1);
      check($sformatf("rnd%0d_busy", run), 64'(busy), 64'd0);
      if (!over) check($sformatf("rnd%0d_all_words", run), 64'(exp_next), 64'(LAST + 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the 32-entry combinational instruction ROM. It owns the program counter, drives the ROM address, and captures each returned word with its PC into a small fetch buffer. The buffer feeds the decode stage through a valid/ready handshake. Sits between the ROM and decode, and accepts start and branch-redirect commands from the core control.

## Interface
Parameters:
- ADDR_W, 5: ROM word-address width.
- DATA_W, 32: instruction width.
- LAST_ADDR, 5'd14: highest populated ROM word; fetch stops after it. Must be ≤ 2^ADDR_W−1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin fetching at PC 0; sampled only in IDLE or DONE.
- redirect_valid  in  1  branch redirect request.
- redirect_addr  in  ADDR_W  redirect target word address.
- rom_addr  out  ADDR_W  ROM address; equals the current PC register.
- rom_instr  in  DATA_W  ROM data, combinational from rom_addr.
- out_valid  out  1  buffer head valid.
- out_instr  out  DATA_W  buffer head instruction.
- out_pc  out  ADDR_W  buffer head PC.
- out_ready  in  1  decode accepts head.
- busy  out  1  state is FETCH or DRAIN.
- done  out  1  state is DONE.

## Operation
- States: IDLE, FETCH, DRAIN, DONE. Reset enters IDLE.
- IDLE/DONE: on start → FETCH, pc←0, buffer flushed. redirect_valid is ignored.
- FETCH: each cycle the push condition is (buffer not full) OR (pop this cycle). When it holds, push {pc, rom_instr}. If pc==LAST_ADDR → DRAIN with pc held; else pc←pc+1. There is no wraparound; pc never exceeds LAST_ADDR through increment.
- DRAIN: no pushes. When the buffer is empty (after any pop this cycle) → DONE.
- Redirect in FETCH or DRAIN:
  - Buffer is flushed.
  - pc←redirect_addr.
  - No push occurs that cycle.
  - If redirect_addr ≤ LAST_ADDR → FETCH; else → DRAIN, which reaches DONE the following cycle.
- Redirect wins over a normal push in the same cycle. A pop handshake in the same cycle as a redirect still completes; the consumer keeps that word.
- Fetch buffer: 2-entry FIFO. A pop occurs when out_valid && out_ready. When full, push and pop in the same cycle are both allowed.
- out_instr and out_pc are held stable while out_valid && !out_ready.

## Timing
- Reset values: rom_addr=0, out_valid=0, out_instr=0, out_pc=0, busy=0, done=0. The buffer is empty.
- Reset asserted mid-fetch immediately clears all state and outputs, regardless of the clock.
- Start latency:
  - start sampled high at edge N → FETCH, with pc=0 after N.
  - The push of word 0 occurs at edge N+1; out_valid=1 after N+1.
- Throughput: 1 instruction/cycle when out_ready is held high.
- Redirect latency: redirect sampled at edge N → out_valid=0 after N. The target word is pushed at N+1 and is valid after N+1.
- done rises one cycle after the last pop of the final word.

## Structure
- Shared package (fetch_pkg): state enum {IDLE, FETCH, DRAIN, DONE}, ADDR_W/DATA_W defaults, and a typedef for the buffer entry {pc, instr}.
- Sub-module fetch_fifo: 2-entry synchronous FIFO.
  - Push/pop interface with full/empty outputs.
  - Synchronous flush input.
  - Asynchronous active-low reset.
- fetch_ctrl contains only the FSM, the PC register, and the push/flush control.

## Test plan
Bench ROM model returns 32'hA000_0000 | addr.
- Reset, then start pulse with out_ready=1 → out_pc 0..14 on 15 consecutive cycles (out_instr 32'hA000_0000..32'hA000_000E), then done=1 one cycle after the last pop; rom_addr never exceeds 14.
- Start with out_ready=0 for 5 cycles → buffer holds PC 0,1; rom_addr stays 2; out_pc=0 is stable. Raising out_ready then delivers 0,1,2,… with no gap or duplicate.
- Redirect to 9 while out_pc=3 is handshaking → PC 3 is accepted; the next out_valid word is PC 9 (32'hA000_0009), one cycle after the redirect; the old PC 4 never appears.
- Redirect to 20 (> LAST_ADDR) in FETCH → out_valid=0 next cycle; done=1 the cycle after; a later start restarts at PC 0.
- Redirect in DONE and in IDLE → ignored; state and outputs are unchanged.
- Assert rst_n low mid-FETCH between clock edges → all outputs drop to reset values immediately; after release the block stays IDLE until start.
